// File: rtl/sa_autosa_glb_pkg.sv
// Shared constants for the AutoSA global interrupt controller: CSB offsets,
// version defaults and the channel-count helper.
package sa_autosa_glb_pkg;

  localparam int unsigned GLB_HW_VERSION_OFS = 'h00;
  localparam int unsigned GLB_MASK_OFS       = 'h04;
  localparam int unsigned GLB_SET_OFS        = 'h08;
  localparam int unsigned GLB_STATUS_OFS     = 'h0C;
  localparam int unsigned GLB_OVF_OFS        = 'h10;
  localparam int unsigned GLB_CTRL_OFS       = 'h14;

  localparam logic [7:0]  GLB_HW_MAJOR_DEF = 8'h31;
  localparam logic [15:0] GLB_HW_MINOR_DEF = 16'h3030;

  // Each engine source owns a ping and a pong done channel.
  function automatic int unsigned glb_ch_width(input int unsigned num_src);
    return 2 * num_src;
  endfunction

endpackage

// File: rtl/sa_autosa_intr_bit.sv
// One interrupt channel: sticky status (set beats clear) and a lost-event
// flag raised when hardware done arrives on an already-pending status.
module sa_autosa_intr_bit (
  input  logic autosa_core_clk,
  input  logic autosa_core_rstn,
  input  logic hw_set,
  input  logic sw_set,
  input  logic clr,
  input  logic ovf_clr,
  output logic status,
  output logic ovf
);

  logic status_reg, status_next;
  logic ovf_reg, ovf_next;

  always_comb begin
    status_next = status_reg;
    if (hw_set || sw_set)
      status_next = 1'b1;
    else if (clr)
      status_next = 1'b0;

    // Only hardware events count as lost; a software SET onto a pending bit does not.
    ovf_next = ovf_reg;
    if (hw_set && status_reg)
      ovf_next = 1'b1;
    else if (ovf_clr)
      ovf_next = 1'b0;
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      status_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      status_reg <= status_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign status = status_reg;
  assign ovf    = ovf_reg;

endmodule

// File: rtl/sa_autosa_glb_intr_ctrl.sv
// AutoSA global interrupt controller: CSB register decode, per-channel
// status/overflow flops, mask/enable and the registered host interrupt.
module sa_autosa_glb_intr_ctrl
  import sa_autosa_glb_pkg::*;
#(
  parameter int          NUM_SRC  = 8,
  parameter int          ADDR_W   = 12,
  parameter logic [7:0]  HW_MAJOR = GLB_HW_MAJOR_DEF,
  parameter logic [15:0] HW_MINOR = GLB_HW_MINOR_DEF
) (
  input  logic                   autosa_core_clk,
  input  logic                   autosa_core_rstn,
  input  logic [ADDR_W-1:0]      reg_offset,
  input  logic                   reg_wr_en,
  input  logic [31:0]            reg_wr_data,
  output logic [31:0]            reg_rd_data,
  input  logic [2*NUM_SRC-1:0]   done_pulse,
  output logic [2*NUM_SRC-1:0]   intr_mask,
  output logic [2*NUM_SRC-1:0]   intr_status,
  output logic                   core_intr
);

  localparam int CH = int'(glb_ch_width(NUM_SRC));

  logic          hit_version, hit_mask, hit_set, hit_status, hit_ovf, hit_ctrl;
  logic          wr_mask, wr_set, wr_status, wr_ovf, wr_ctrl;
  logic [CH-1:0] mask_reg, mask_next;
  logic          enable_reg, enable_next;
  logic          core_intr_reg, core_intr_next;
  logic [CH-1:0] status_vec, ovf_vec;
  logic          unused_wr_bits;

  assign hit_version = (reg_offset == ADDR_W'(GLB_HW_VERSION_OFS));
  assign hit_mask    = (reg_offset == ADDR_W'(GLB_MASK_OFS));
  assign hit_set     = (reg_offset == ADDR_W'(GLB_SET_OFS));
  assign hit_status  = (reg_offset == ADDR_W'(GLB_STATUS_OFS));
  assign hit_ovf     = (reg_offset == ADDR_W'(GLB_OVF_OFS));
  assign hit_ctrl    = (reg_offset == ADDR_W'(GLB_CTRL_OFS));

  assign wr_mask   = reg_wr_en & hit_mask;
  assign wr_set    = reg_wr_en & hit_set;
  assign wr_status = reg_wr_en & hit_status;
  assign wr_ovf    = reg_wr_en & hit_ovf;
  assign wr_ctrl   = reg_wr_en & hit_ctrl;

  // Upper write-data bits beyond the channel count are architecturally ignored.
  assign unused_wr_bits = ^reg_wr_data;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      sa_autosa_intr_bit u_bit (
        .autosa_core_clk  (autosa_core_clk),
        .autosa_core_rstn (autosa_core_rstn),
        .hw_set           (done_pulse[gi]),
        .sw_set           (wr_set & reg_wr_data[gi]),
        .clr              (wr_status & reg_wr_data[gi]),
        .ovf_clr          (wr_ovf & reg_wr_data[gi]),
        .status           (status_vec[gi]),
        .ovf              (ovf_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    mask_next      = wr_mask ? reg_wr_data[CH-1:0] : mask_reg;
    enable_next    = wr_ctrl ? reg_wr_data[0] : enable_reg;
    core_intr_next = enable_reg & (|(status_vec & ~mask_reg));
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      mask_reg      <= '0;
      enable_reg    <= 1'b0;
      core_intr_reg <= 1'b0;
    end else begin
      mask_reg      <= mask_next;
      enable_reg    <= enable_next;
      core_intr_reg <= core_intr_next;
    end
  end

  always_comb begin
    reg_rd_data = 32'h0;
    if (hit_version)
      reg_rd_data = {8'h00, HW_MINOR, HW_MAJOR};
    else if (hit_mask)
      reg_rd_data = 32'(mask_reg);
    else if (hit_status)
      reg_rd_data = 32'(status_vec);
    else if (hit_ovf)
      reg_rd_data = 32'(ovf_vec);
    else if (hit_ctrl)
      reg_rd_data = {31'h0, enable_reg};
  end

  assign intr_mask   = mask_reg;
  assign intr_status = status_vec;
  assign core_intr   = core_intr_reg;

endmodule

// File: tb/tb_sa_autosa_glb_intr_ctrl.sv
// Scoreboard bench for sa_autosa_glb_intr_ctrl: directed scenarios plus
// randomized register traffic checked against a vector-level reference model.
module tb_sa_autosa_glb_intr_ctrl;

  localparam int NUM_SRC = 8;
  localparam int CH      = 2 * NUM_SRC;
  localparam logic [11:0] O_VER = 12'h000, O_MASK = 12'h004, O_SET = 12'h008;
  localparam logic [11:0] O_STAT = 12'h00C, O_OVF = 12'h010, O_CTRL = 12'h014;
  localparam logic [31:0] VERSION = 32'h00303031;

  localparam int K_RD = 0, K_ST = 1, K_MK = 2, K_IN = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [11:0]   reg_offset = '0;
  logic          reg_wr_en = 1'b0;
  logic [31:0]   reg_wr_data = '0;
  logic [31:0]   reg_rd_data;
  logic [CH-1:0] done_pulse = '0;
  logic [CH-1:0] intr_mask;
  logic [CH-1:0] intr_status;
  logic          core_intr;

  sa_autosa_glb_intr_ctrl #(.NUM_SRC(NUM_SRC), .ADDR_W(12)) dut (
    .autosa_core_clk  (clk),
    .autosa_core_rstn (rstn),
    .reg_offset       (reg_offset),
    .reg_wr_en        (reg_wr_en),
    .reg_wr_data      (reg_wr_data),
    .reg_rd_data      (reg_rd_data),
    .done_pulse       (done_pulse),
    .intr_mask        (intr_mask),
    .intr_status      (intr_status),
    .core_intr        (core_intr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic [11:0] ofs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn = 0;

  // Reference model state: what the architectural registers hold after the latest edge.
  logic [CH-1:0] m_status = '0, m_ovf = '0, m_mask = '0;
  logic          m_en = 1'b0, m_intr = 1'b0;

  function automatic string kind_name(input int k);
    case (k)
      K_RD:    return "rd_data";
      K_ST:    return "intr_status";
      K_MK:    return "intr_mask";
      default: return "core_intr";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] off);
    case (off)
      O_VER:   return VERSION;
      O_MASK:  return 32'(m_mask);
      O_STAT:  return 32'(m_status);
      O_OVF:   return 32'(m_ovf);
      O_CTRL:  return {31'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic [11:0] off, input logic we,
                            input logic [31:0] wd, input logic [CH-1:0] dn);
    logic [CH-1:0] sets, clears, oclears, lost;
    logic          intr_new;
    intr_new = m_en & (|(m_status & ~m_mask));
    sets     = dn | ((we && off == O_SET) ? wd[CH-1:0] : '0);
    clears   = (we && off == O_STAT) ? wd[CH-1:0] : '0;
    oclears  = (we && off == O_OVF) ? wd[CH-1:0] : '0;
    lost     = dn & m_status;
    m_ovf    = lost | (m_ovf & ~oclears);
    m_status = sets | (m_status & ~clears);
    if (we && off == O_MASK) m_mask = wd[CH-1:0];
    if (we && off == O_CTRL) m_en = wd[0];
    m_intr = intr_new;
  endtask

  task automatic push(input int kind, input logic [31:0] v, input logic [11:0] off);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    e.ofs  = off;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus; expectations for this cycle's outputs come from
  // the model before this cycle's edge is applied.
  task automatic cycle(input logic [11:0] off, input logic we,
                       input logic [31:0] wd, input logic [CH-1:0] dn);
    reg_offset  = off;
    reg_wr_en   = we;
    reg_wr_data = wd;
    done_pulse  = dn;
    push(K_RD, model_read(off), off);
    push(K_ST, 32'(m_status), off);
    push(K_MK, 32'(m_mask), off);
    push(K_IN, {31'h0, m_intr}, off);
    n_txn++;
    $display("txn %0d: ofs=%h we=%b wd=%h done=%h", n_txn, off, we, wd, dn);
    @(posedge clk);
    model_step(off, we, wd, dn);
    #1;
  endtask

  task automatic idle(input logic [11:0] off);
    cycle(off, 1'b0, 32'h0, '0);
  endtask

  always @(negedge clk) begin
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      case (e.kind)
        K_RD:    act = reg_rd_data;
        K_ST:    act = 32'(intr_status);
        K_MK:    act = 32'(intr_mask);
        default: act = {31'h0, core_intr};
      endcase
      check($sformatf("%s@%h", kind_name(e.kind), e.ofs), act, e.val);
    end
  end

  task automatic model_reset();
    m_status = '0;
    m_ovf    = '0;
    m_mask   = '0;
    m_en     = 1'b0;
    m_intr   = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset values and version
    push(K_RD, VERSION, O_VER);  idle(O_VER);
    push(K_RD, 32'h0, O_MASK);   idle(O_MASK);
    push(K_RD, 32'h0, O_STAT);   idle(O_STAT);
    push(K_RD, 32'h0, O_OVF);    idle(O_OVF);
    push(K_IN, 32'h0, O_CTRL);   idle(O_CTRL);

    // Basic interrupt path and W1C
    cycle(O_CTRL, 1'b1, 32'h1, '0);
    cycle(O_MASK, 1'b1, 32'h0, '0);
    cycle(O_STAT, 1'b0, 32'h0, CH'(16'h0008));
    push(K_RD, 32'h8, O_STAT); push(K_IN, 32'h0, O_STAT); idle(O_STAT);
    push(K_IN, 32'h1, O_STAT); idle(O_STAT);
    cycle(O_STAT, 1'b1, 32'h8, '0);
    push(K_RD, 32'h0, O_STAT); push(K_IN, 32'h1, O_STAT); idle(O_STAT);
    push(K_IN, 32'h0, O_STAT); idle(O_STAT);

    // Masked source still sets status; unmask raises interrupt one edge later
    cycle(O_MASK, 1'b1, 32'hFFFF, '0);
    cycle(O_STAT, 1'b0, 32'h0, CH'(16'h0001));
    push(K_RD, 32'h1, O_STAT); idle(O_STAT);
    push(K_IN, 32'h0, O_STAT); idle(O_STAT);
    cycle(O_MASK, 1'b1, 32'h0, '0);
    push(K_IN, 32'h0, O_STAT); idle(O_STAT);
    push(K_IN, 32'h1, O_STAT); idle(O_STAT);

    // Overflow tracking
    cycle(O_STAT, 1'b1, 32'hFFFF, '0);
    cycle(O_SET, 1'b1, 32'h20, '0);
    cycle(O_OVF, 1'b0, 32'h0, CH'(16'h0020));
    push(K_RD, 32'h20, O_OVF); idle(O_OVF);
    cycle(O_OVF, 1'b1, 32'h20, CH'(16'h0020));
    push(K_RD, 32'h20, O_OVF); idle(O_OVF);
    cycle(O_OVF, 1'b1, 32'h20, '0);
    push(K_RD, 32'h0, O_OVF); idle(O_OVF);
    cycle(O_SET, 1'b1, 32'h20, '0);
    push(K_RD, 32'h0, O_OVF); idle(O_OVF);

    // Hardware set beats a same-cycle W1C
    cycle(O_STAT, 1'b1, 32'hFFFF, '0);
    cycle(O_STAT, 1'b1, 32'h4, CH'(16'h0004));
    push(K_RD, 32'h4, O_STAT); idle(O_STAT);

    // Read-only, unmapped and upper-bit handling
    cycle(O_VER, 1'b1, 32'hFFFFFFFF, '0);
    cycle(12'h018, 1'b1, 32'hFFFFFFFF, '0);
    cycle(O_SET, 1'b1, 32'hFFFFFFFF, '0);
    push(K_RD, VERSION, O_VER); idle(O_VER);
    push(K_RD, 32'h0, 12'h018); idle(12'h018);
    push(K_RD, 32'h0000FFFF, O_STAT); idle(O_STAT);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [11:0] off;
      logic        we;
      logic [31:0] wd;
      logic [CH-1:0] dn;
      off = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 7) * 4);
      we  = ($urandom_range(0, 2) == 0);
      wd  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      dn  = CH'($urandom & $urandom & $urandom);
      cycle(off, we, wd, dn);
    end

    // Load state, then assert reset asynchronously mid-cycle
    cycle(O_MASK, 1'b1, 32'h0, '0);
    cycle(O_SET, 1'b1, 32'hFFFF, '0);
    cycle(O_CTRL, 1'b1, 32'h1, '0);
    cycle(O_MASK, 1'b1, 32'h00F0, '0);
    push(K_IN, 32'h1, O_STAT); idle(O_STAT);
    reg_offset = O_STAT;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_status", 32'(intr_status), 32'h0);
    check("async_rst_mask", 32'(intr_mask), 32'h0);
    check("async_rst_core_intr", {31'h0, core_intr}, 32'h0);
    check("async_rst_rd_status", reg_rd_data, 32'h0);
    done_pulse = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ignores_done", 32'(intr_status), 32'h0);
    done_pulse = '0;
    model_reset();
    rstn = 1'b1;
    push(K_RD, VERSION, O_VER); idle(O_VER);
    push(K_RD, 32'h0, O_CTRL); idle(O_CTRL);
    idle(O_STAT);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
